backscatter_sequencer: RTL and testbench
========================================

BACKSCATTER_SEQUENCER -- requirements
Module: backscatter_sequencer

Interface
REQ-001 Parameter SHIFT_HALF, default 2: subcarrier half-period in clocks.
REQ-002 Parameter PREAMBLE_CYCLES, default 400: clocks between the trigger edge and the first modulated symbol.
REQ-003 Parameter SYMBOL_CYCLES, default 40: clocks per payload bit; must be a multiple of 2*SHIFT_HALF, otherwise elaboration error.
REQ-004 Parameter FRAME_BYTES, default 4: payload bytes per frame, minimum 1.
REQ-005 clock  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 trigger_signal  in  1  packet-detect level, already synchronous to clock.
REQ-008 tx_data  in  8  payload byte.
REQ-009 tx_valid  in  1  tx_data valid.
REQ-010 tx_ready  out  1  sequencer can accept a byte this cycle.
REQ-011 signal_into_switch  out  1  RF switch drive, registered.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 frame_done  out  1  one-cycle pulse on completed frame.
REQ-014 underrun  out  1  one-cycle pulse on aborted frame.

Function
REQ-015 FSM states SHALL be IDLE, DELAY, SEND and DONE.
REQ-016 Trigger rise SHALL be trigger_signal=1 with its registered previous value=0; a rise accepted only in IDLE, ignored otherwise.
REQ-017 IDLE->DELAY on the cycle after a rise is sampled; DELAY SHALL last exactly PREAMBLE_CYCLES cycles.
REQ-018 One-byte holding buffer; tx_ready = buffer empty AND state in {DELAY, SEND} AND bytes accepted this frame < FRAME_BYTES; transfer on tx_valid&tx_ready.
REQ-019 DELAY->SEND loads the shift register from the buffer; if the buffer is empty at that boundary, underrun pulses, state goes to IDLE.
REQ-020 Bits SHALL be sent LSB first, each held SYMBOL_CYCLES clocks; after bit 7 of a non-final byte the next byte loads from the buffer, and an empty buffer SHALL raise underrun and return to IDLE.
REQ-021 Subcarrier SHALL restart at phase 0 (low) on SEND entry, toggling every SHIFT_HALF clocks.
REQ-022 In SEND, signal_into_switch = subcarrier XOR current bit (bit 1 = 180-degree phase flip); 0 in IDLE, DELAY, DONE.
REQ-023 After FRAME_BYTES*8 bits, SEND->DONE for one cycle with frame_done=1, then IDLE.
REQ-024 A byte accepted in the same cycle it is needed SHALL count as available (no underrun).
REQ-025 Counter widths SHALL be $clog2 of their terminal count plus one; no counter wraps within a frame.

Reset
REQ-026 On reset, the cycle after assertion: state IDLE; signal_into_switch, tx_ready, busy, frame_done, underrun all 0; buffer emptied; counters and edge register cleared.
REQ-027 Reset mid-frame SHALL abort without frame_done or underrun pulse; a trigger held high through reset release SHALL NOT count as a rise.

Structure
REQ-028 Shared package hitchhike_pkg SHALL hold the state encoding and default parameter constants.
REQ-029 Subcarrier toggle logic SHALL be a sub-module subcarrier_gen (enable, phase restart, SHIFT_HALF).

Verification (SHIFT_HALF=1, PREAMBLE_CYCLES=8, SYMBOL_CYCLES=4, FRAME_BYTES=2)
REQ-030 Bytes 0xA5,0x3C pre-loaded, trigger rise -> busy 1 cycle later, switch 0 for 8 cycles, then 64 cycles matching (0101 XOR bit)-per-symbol for LSB-first 0xA5,0x3C, then frame_done one pulse, busy 0.
REQ-031 Trigger rise, no tx_valid -> underrun pulses at end of DELAY, switch stays 0, IDLE next cycle.
REQ-032 First byte only, second withheld -> underrun exactly after bit 7 of byte 0 (cycle 32 of SEND), no frame_done.
REQ-033 Second trigger rise during SEND -> ignored; frame completes unchanged, exactly one frame_done.
REQ-034 Reset asserted at SEND cycle 10 -> next cycle all outputs 0, IDLE; trigger held high across release produces no frame.
REQ-035 Byte 1 presented with tx_valid in the exact load cycle -> no underrun, waveform continuous.

Source files
------------

// File: rtl/hitchhike_pkg.sv
// Shared state encoding and default parameters for the backscatter sequencer.
package hitchhike_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_SHIFT_HALF      = 2;
  localparam int unsigned DEF_PREAMBLE_CYCLES = 400;
  localparam int unsigned DEF_SYMBOL_CYCLES   = 40;
  localparam int unsigned DEF_FRAME_BYTES     = 4;
  localparam int unsigned BYTE_BITS           = 8;

endpackage

// File: rtl/subcarrier_gen.sv
// Square-wave subcarrier toggling every SHIFT_HALF clocks; restart forces phase 0.
// phase_c is the phase the register will hold next cycle, so callers can register it aligned.
module subcarrier_gen
  import hitchhike_pkg::*;
#(
  parameter int unsigned SHIFT_HALF = DEF_SHIFT_HALF
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic phase_c
);

  localparam int unsigned CNT_W = $clog2(SHIFT_HALF) + 1;

  logic [CNT_W-1:0] cnt, cnt_n;
  logic             phase, phase_n;

  always_comb begin
    cnt_n   = cnt;
    phase_n = phase;
    if (restart) begin
      cnt_n   = '0;
      phase_n = 1'b0;
    end else if (enable) begin
      if (cnt == CNT_W'(SHIFT_HALF - 1)) begin
        cnt_n   = '0;
        phase_n = ~phase;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      phase <= phase_n;
    end
  end

  assign phase_c = phase_n;

endmodule

// File: rtl/backscatter_sequencer.sv
// Trigger-started backscatter frame sequencer: preamble delay, then LSB-first payload
// bits BPSK-modulated onto the subcarrier that drives the RF switch.
module backscatter_sequencer
  import hitchhike_pkg::*;
#(
  parameter int unsigned SHIFT_HALF      = DEF_SHIFT_HALF,
  parameter int unsigned PREAMBLE_CYCLES = DEF_PREAMBLE_CYCLES,
  parameter int unsigned SYMBOL_CYCLES   = DEF_SYMBOL_CYCLES,
  parameter int unsigned FRAME_BYTES     = DEF_FRAME_BYTES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger_signal,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       signal_into_switch,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned DLY_W  = $clog2(PREAMBLE_CYCLES) + 1;
  localparam int unsigned SYM_W  = $clog2(SYMBOL_CYCLES) + 1;
  localparam int unsigned BIT_W  = $clog2(BYTE_BITS) + 1;
  localparam int unsigned BYTE_W = $clog2(FRAME_BYTES) + 1;

  if ((SYMBOL_CYCLES % (2 * SHIFT_HALF)) != 0) begin : g_bad_symbol
    $error("SYMBOL_CYCLES must be a multiple of 2*SHIFT_HALF");
  end
  if (FRAME_BYTES < 1 || SHIFT_HALF < 1 || PREAMBLE_CYCLES < 1) begin : g_bad_size
    $error("FRAME_BYTES, SHIFT_HALF and PREAMBLE_CYCLES must be at least 1");
  end

  state_t            state, state_n;
  logic [DLY_W-1:0]  dly_cnt, dly_n;
  logic [SYM_W-1:0]  sym_cnt, sym_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [BYTE_W-1:0] byte_cnt, byte_n;
  logic [BYTE_W-1:0] acc_cnt, acc_n;
  logic [7:0]        shreg, shreg_n;
  logic [7:0]        buf_data, buf_data_n;
  logic              buf_full, buf_full_n;
  logic              trig_q, armed;
  logic              rise, accept, avail, consume;
  logic [7:0]        byte_in;
  logic              ready_n, switch_n, busy_n, done_n, underrun_n;
  logic              sc_phase_c;

  // armed stays low until a real low sample replaces the reset value of trig_q
  assign rise    = trigger_signal & ~trig_q & armed;
  assign accept  = tx_valid & tx_ready;
  assign avail   = buf_full | accept;
  assign byte_in = buf_full ? buf_data : tx_data;

  subcarrier_gen #(
    .SHIFT_HALF(SHIFT_HALF)
  ) u_subcarrier (
    .clock   (clock),
    .reset   (reset),
    .enable  (state == ST_SEND),
    .restart (state == ST_DELAY),
    .phase_c (sc_phase_c)
  );

  always_comb begin
    state_n    = state;
    dly_n      = dly_cnt;
    sym_n      = sym_cnt;
    bit_n      = bit_idx;
    byte_n     = byte_cnt;
    acc_n      = acc_cnt;
    shreg_n    = shreg;
    buf_data_n = buf_data;
    buf_full_n = buf_full;
    consume    = 1'b0;
    done_n     = 1'b0;
    underrun_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n    = ST_DELAY;
          dly_n      = '0;
          acc_n      = '0;
          buf_full_n = 1'b0;
        end
      end
      ST_DELAY: begin
        if (dly_cnt == DLY_W'(PREAMBLE_CYCLES - 1)) begin
          if (avail) begin
            state_n = ST_SEND;
            shreg_n = byte_in;
            consume = 1'b1;
            sym_n   = '0;
            bit_n   = '0;
            byte_n  = '0;
          end else begin
            state_n    = ST_IDLE;
            underrun_n = 1'b1;
          end
        end else begin
          dly_n = dly_cnt + DLY_W'(1);
        end
      end
      ST_SEND: begin
        if (sym_cnt == SYM_W'(SYMBOL_CYCLES - 1)) begin
          sym_n = '0;
          if (bit_idx == BIT_W'(BYTE_BITS - 1)) begin
            if (byte_cnt == BYTE_W'(FRAME_BYTES - 1)) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else if (avail) begin
              shreg_n = byte_in;
              consume = 1'b1;
              bit_n   = '0;
              byte_n  = byte_cnt + BYTE_W'(1);
            end else begin
              state_n    = ST_IDLE;
              underrun_n = 1'b1;
            end
          end else begin
            shreg_n = shreg >> 1;
            bit_n   = bit_idx + BIT_W'(1);
          end
        end else begin
          sym_n = sym_cnt + SYM_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // a byte arriving in its load cycle bypasses the holding buffer
    if (consume) begin
      buf_full_n = 1'b0;
    end else if (accept) begin
      buf_full_n = 1'b1;
      buf_data_n = tx_data;
    end
    if (accept) acc_n = acc_cnt + BYTE_W'(1);

    ready_n  = ~buf_full_n & ((state_n == ST_DELAY) | (state_n == ST_SEND))
               & (acc_n < BYTE_W'(FRAME_BYTES));
    switch_n = (state_n == ST_SEND) & (sc_phase_c ^ shreg_n[0]);
    busy_n   = (state_n != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= ST_IDLE;
      dly_cnt            <= '0;
      sym_cnt            <= '0;
      bit_idx            <= '0;
      byte_cnt           <= '0;
      acc_cnt            <= '0;
      shreg              <= '0;
      buf_data           <= '0;
      buf_full           <= 1'b0;
      trig_q             <= 1'b0;
      armed              <= 1'b0;
      tx_ready           <= 1'b0;
      signal_into_switch <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      underrun           <= 1'b0;
    end else begin
      state              <= state_n;
      dly_cnt            <= dly_n;
      sym_cnt            <= sym_n;
      bit_idx            <= bit_n;
      byte_cnt           <= byte_n;
      acc_cnt            <= acc_n;
      shreg              <= shreg_n;
      buf_data           <= buf_data_n;
      buf_full           <= buf_full_n;
      trig_q             <= trigger_signal;
      armed              <= armed | ~trigger_signal;
      tx_ready           <= ready_n;
      signal_into_switch <= switch_n;
      busy               <= busy_n;
      frame_done         <= done_n;
      underrun           <= underrun_n;
    end
  end

endmodule

// File: tb/tb_backscatter_sequencer.sv
// Directed bench for backscatter_sequencer with short preamble/symbol parameters.
module tb_backscatter_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger_signal;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       signal_into_switch;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] feed_q[$];

  backscatter_sequencer #(
    .SHIFT_HALF      (1),
    .PREAMBLE_CYCLES (8),
    .SYMBOL_CYCLES   (4),
    .FRAME_BYTES     (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .trigger_signal     (trigger_signal),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .signal_into_switch (signal_into_switch),
    .busy               (busy),
    .frame_done         (frame_done),
    .underrun           (underrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // present the queued byte; it is accepted at the next edge iff tx_ready is high now
  task automatic drive();
    if (feed_q.size() > 0) begin
      tx_valid = 1'b1;
      tx_data  = feed_q[0];
      if (tx_ready) void'(feed_q.pop_front());
    end else begin
      tx_valid = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    drive();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".switch"}, signal_into_switch, 1'b0);
    check({tag, ".ready"}, tx_ready, 1'b0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, frame_done, 1'b0);
    check({tag, ".underrun"}, underrun, 1'b0);
  endtask

  // trigger and walk through DELAY; returns at the first cycle after DELAY
  task automatic start_and_delay(input string tag);
    trigger_signal = 1'b1;
    cyc();
    trigger_signal = 1'b0;
    check({tag, ".busy_after_rise"}, busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check({tag, ".delay_switch"}, signal_into_switch, 1'b0);
      check({tag, ".delay_underrun"}, underrun, 1'b0);
      cyc();
    end
  endtask

  function automatic logic exp_switch(input logic [7:0] b0, input logic [7:0] b1, input int k);
    logic [7:0] cur;
    cur = (k < 32) ? b0 : b1;
    return cur[(k % 32) / 4] ^ ((k % 2) == 1);
  endfunction

  // full frame; late=1 withholds byte 1 until its exact load cycle
  task automatic send_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input bit retrig, input bit late);
    feed_q.push_back(b0);
    if (!late) feed_q.push_back(b1);
    start_and_delay(tag);
    for (int k = 0; k < 64; k++) begin
      check({tag, ".send_switch"}, signal_into_switch, exp_switch(b0, b1, k));
      check({tag, ".send_busy"}, busy, 1'b1);
      check({tag, ".send_underrun"}, underrun, 1'b0);
      check({tag, ".send_done"}, frame_done, 1'b0);
      if (retrig && k == 10) trigger_signal = 1'b1;
      if (retrig && k == 14) trigger_signal = 1'b0;
      if (late && k == 30) feed_q.push_back(b1);
      cyc();
    end
    check({tag, ".done_pulse"}, frame_done, 1'b1);
    check({tag, ".done_busy"}, busy, 1'b1);
    check({tag, ".done_switch"}, signal_into_switch, 1'b0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check_all_zero({tag, ".after"});
      cyc();
    end
  endtask

  initial begin
    reset          = 1'b1;
    trigger_signal = 1'b0;
    tx_data        = 8'h00;
    tx_valid       = 1'b0;
    cyc();
    cyc();
    check_all_zero("reset");
    reset = 1'b0;
    cyc();
    cyc();
    check_all_zero("idle");

    send_frame("frame_a5_3c", 8'hA5, 8'h3C, 1'b0, 1'b0);

    // no payload at all: underrun at end of DELAY
    start_and_delay("no_data");
    check("no_data.underrun", underrun, 1'b1);
    check("no_data.busy", busy, 1'b0);
    check("no_data.switch", signal_into_switch, 1'b0);
    cyc();
    check_all_zero("no_data.after");

    // only byte 0: underrun right after its bit 7
    feed_q.push_back(8'hC3);
    start_and_delay("one_byte");
    for (int k = 0; k < 32; k++) begin
      check("one_byte.send_switch", signal_into_switch, exp_switch(8'hC3, 8'h00, k));
      check("one_byte.send_underrun", underrun, 1'b0);
      cyc();
    end
    check("one_byte.underrun", underrun, 1'b1);
    check("one_byte.busy", busy, 1'b0);
    check("one_byte.done", frame_done, 1'b0);
    check("one_byte.switch", signal_into_switch, 1'b0);
    cyc();
    check_all_zero("one_byte.after");

    send_frame("retrigger", 8'h5A, 8'hF0, 1'b1, 1'b0);

    // reset at SEND cycle 10 with trigger held through release
    feed_q.push_back(8'hA5);
    feed_q.push_back(8'h3C);
    start_and_delay("mid_reset");
    for (int k = 0; k < 10; k++) cyc();
    check("mid_reset.busy_before", busy, 1'b1);
    reset          = 1'b1;
    trigger_signal = 1'b1;
    cyc();
    check_all_zero("mid_reset.in_reset");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_all_zero("mid_reset.held_trigger");
    end
    trigger_signal = 1'b0;
    cyc();
    cyc();
    check_all_zero("mid_reset.released");

    send_frame("late_byte", 8'h96, 8'h0F, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
